// File: rtl/my_dmux_stream.sv
// Registered 1-to-2 stream demultiplexer with valid/ready on every side.
// Define MY_DMUX_STREAM_COUNT_EN to add per-port 16-bit transfer counters.
module my_dmux_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             busy
`ifdef MY_DMUX_STREAM_COUNT_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A stalled output blocks the input entirely, so word ordering stays strict.
    always_comb begin
        drain    = ((state_q == HOLD_A) && a_ready) || ((state_q == HOLD_B) && b_ready);
        in_ready = (state_q == EMPTY) || drain;
        accept   = in_valid && in_ready;
        state_d  = state_q;
        data_d   = data_q;
        if (accept) begin
            state_d = in_sel ? HOLD_B : HOLD_A;
            data_d  = in_data;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    assign a_valid = (state_q == HOLD_A);
    assign b_valid = (state_q == HOLD_B);
    assign a_data  = a_valid ? data_q : '0;
    assign b_data  = b_valid ? data_q : '0;
    assign busy    = (state_q != EMPTY);

`ifdef MY_DMUX_STREAM_COUNT_EN
    logic [15:0] a_count_q, a_count_d;
    logic [15:0] b_count_q, b_count_d;

    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_valid && a_ready) a_count_d = a_count_q + 16'd1;
        if (b_valid && b_ready) b_count_d = b_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_my_dmux_stream.sv
// Self-checking bench for my_dmux_stream: directed scenarios plus a randomized
// run against a one-slot buffer reference model.
module tb_my_dmux_stream;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic             busy;
`ifdef MY_DMUX_STREAM_COUNT_EN
    logic [15:0]      a_count;
    logic [15:0]      b_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a single slot that either holds a word for a port or is empty.
    logic             m_has;
    logic             m_sel;
    logic [WIDTH-1:0] m_data;
    int               m_a_done;
    int               m_b_done;

    my_dmux_stream #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .busy     (busy)
`ifdef MY_DMUX_STREAM_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    always #5 clk = ~clk;

    // Advances one clock and updates the model; called with inputs stable after a negedge.
    task automatic step();
        logic rdy, acc, done;
        done = m_has && (m_sel ? b_ready : a_ready);
        rdy  = !m_has || done;
        acc  = in_valid && rdy;
        @(posedge clk);
        if (done) begin
            if (m_sel) m_b_done++;
            else       m_a_done++;
            m_has = 1'b0;
        end
        if (acc) begin
            m_has  = 1'b1;
            m_sel  = in_sel;
            m_data = in_data;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        m_has    = 1'b0;
        m_sel    = 1'b0;
        m_data   = '0;
        m_a_done = 0;
        m_b_done = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({a_valid, b_valid, busy, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl_low got %b exp 0001", {a_valid, b_valid, busy, in_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_valid, b_valid, busy, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl_rel got %b exp 0001", {a_valid, b_valid, busy, in_ready});
        end
        checks++;
        if (a_data !== 8'h00 || b_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h exp 00 00", a_data, b_data);
        end
`ifdef MY_DMUX_STREAM_COUNT_EN
        checks++;
        if (a_count !== 16'd0 || b_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got a=%0d b=%0d exp 0 0", a_count, b_count);
        end
`endif
    endtask

    task automatic test_single_routes();
        for (int s = 0; s < 2; s++) begin
            a_ready  = 1'b1;
            b_ready  = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'hA5;
            in_sel   = s[0];
            step();
            in_valid = 1'b0;
            checks++;
            if (s == 0 && (a_valid !== 1'b1 || a_data !== 8'hA5 || b_valid !== 1'b0 || b_data !== 8'h00)) begin
                errors++;
                $display("FAIL route_a got av=%b ad=%h bv=%b bd=%h exp 1 a5 0 00", a_valid, a_data, b_valid, b_data);
            end
            if (s == 1 && (b_valid !== 1'b1 || b_data !== 8'hA5 || a_valid !== 1'b0 || a_data !== 8'h00)) begin
                errors++;
                $display("FAIL route_b got bv=%b bd=%h av=%b ad=%h exp 1 a5 0 00", b_valid, b_data, a_valid, a_data);
            end
            step();
            checks++;
            if (busy !== 1'b0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL route_empty got busy=%b av=%b bv=%b exp 0 0 0", busy, a_valid, b_valid);
            end
        end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] words [4];
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            in_sel   = i[0];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_rdy%0d got %b exp 1", i, in_ready);
            end
            step();
            checks++;
            if (i[0] == 1'b0 && (a_valid !== 1'b1 || a_data !== words[i] || b_valid !== 1'b0)) begin
                errors++;
                $display("FAIL stream_out%0d got av=%b ad=%h bv=%b exp 1 %h 0", i, a_valid, a_data, b_valid, words[i]);
            end
            if (i[0] == 1'b1 && (b_valid !== 1'b1 || b_data !== words[i] || a_valid !== 1'b0)) begin
                errors++;
                $display("FAIL stream_out%0d got bv=%b bd=%h av=%b exp 1 %h 0", i, b_valid, b_data, a_valid, words[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        a_ready  = 1'b0;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_sel   = 1'b0;
        step();
        in_data  = 8'h22;
        in_sel   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || a_valid !== 1'b1 || a_data !== 8'h11 || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got rdy=%b av=%b ad=%h bv=%b exp 0 1 11 0", i, in_ready, a_valid, a_data, b_valid);
            end
            step();
        end
        a_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_rdy got %b exp 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 8'h22 || a_valid !== 1'b0 || a_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_next got bv=%b bd=%h av=%b ad=%h exp 1 22 0 00", b_valid, b_data, a_valid, a_data);
        end
        step();
    endtask

    task automatic test_idle_ready();
        in_valid = 1'b0;
        a_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_ready = i[0];
            step();
            checks++;
            if (busy !== 1'b0 || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_empty%0d got busy=%b bv=%b exp 0 0", i, busy, b_valid);
            end
        end
        in_valid = 1'b1;
        in_data  = 8'h5C;
        in_sel   = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_ready = ~i[0];
            step();
            checks++;
            if (a_valid !== 1'b1 || a_data !== 8'h5C || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold_a%0d got av=%b ad=%h bv=%b exp 1 5c 0", i, a_valid, a_data, b_valid);
            end
        end
        a_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3E;
        in_sel   = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 8'h3E) begin
            errors++;
            $display("FAIL arst_pre got bv=%b bd=%h exp 1 3e", b_valid, b_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b0 || busy !== 1'b0 || b_data !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_drop got bv=%b busy=%b bd=%h rdy=%b exp 0 0 00 1", b_valid, busy, b_data, in_ready);
        end
        apply_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom);
            in_data  = WIDTH'($urandom);
            a_ready  = ($urandom_range(0, 2) != 0);
            b_ready  = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = !m_has || (m_sel ? b_ready : a_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_rdy cyc%0d got %b exp %b", i, in_ready, exp_rdy);
            end
            step();
            checks++;
            if (a_valid !== (m_has && !m_sel) || b_valid !== (m_has && m_sel) || busy !== m_has ||
                a_data !== ((m_has && !m_sel) ? m_data : 8'h00) ||
                b_data !== ((m_has && m_sel) ? m_data : 8'h00)) begin
                errors++;
                $display("FAIL rand_out cyc%0d got av=%b bv=%b busy=%b ad=%h bd=%h exp slot has=%b sel=%b data=%h",
                         i, a_valid, b_valid, busy, a_data, b_data, m_has, m_sel, m_data);
            end
`ifdef MY_DMUX_STREAM_COUNT_EN
            checks++;
            if (a_count !== 16'(m_a_done) || b_count !== 16'(m_b_done)) begin
                errors++;
                $display("FAIL rand_count cyc%0d got a=%0d b=%0d exp %0d %0d", i, a_count, b_count,
                         16'(m_a_done), 16'(m_b_done));
            end
`endif
        end
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        step();
    endtask

`ifdef MY_DMUX_STREAM_COUNT_EN
    task automatic test_counter();
        apply_reset();
        rst_n = 1'b1;
        @(negedge clk);
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_sel  = (i >= 3);
            in_data = WIDTH'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (a_count !== 16'd3 || b_count !== 16'd2) begin
            errors++;
            $display("FAIL count_small got a=%0d b=%0d exp 3 2", a_count, b_count);
        end
        apply_reset();
        rst_n = 1'b1;
        @(negedge clk);
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            in_data = WIDTH'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (a_count !== 16'd0 || m_a_done != 65536) begin
            errors++;
            $display("FAIL count_wrap got a=%0d done=%0d exp 0 65536", a_count, m_a_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_routes();
        test_streaming();
        test_backpressure();
        test_idle_ready();
        test_async_reset();
        test_random();
`ifdef MY_DMUX_STREAM_COUNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Independent of the scoreboard: the two outputs must never both be valid.
    always @(negedge clk) begin
        if (rst_n && a_valid && b_valid) begin
            checks++;
            errors++;
            $display("FAIL both_valid got a_valid=%b b_valid=%b exp not both", a_valid, b_valid);
        end
    end

endmodule

// File: doc/my_dmux_stream.md
Name: my_dmux_stream

Overview:
- Registered 1-to-2 stream demultiplexer with a valid/ready handshake on every side. It is the sequential stage that feeds the combinational 1-to-2 demux path.
- It captures one word plus its select bit, then presents it on output A (sel=0) or output B (sel=1).
- The non-selected output is held at zero, matching the existing demux semantics.
- Sustains one transfer per cycle when the chosen consumer is ready.

Parameters:
- WIDTH, 8, data width in bits (legal range 1..64)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; release synchronised externally
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 routes to A, 1 routes to B
- in_valid  input  1  producer has word/sel available
- in_ready  output  1  block accepts word this cycle
- a_data  output  WIDTH  held word when routed to A, else 0
- a_valid  output  1  word pending on A
- a_ready  input  1  A consumer accepts
- b_data  output  WIDTH  held word when routed to B, else 0
- b_valid  output  1  word pending on B
- b_ready  input  1  B consumer accepts
- busy  output  1  1 while a word is held (state != EMPTY)

Behaviour:
- One clock; reset is asynchronous and active-low.
- States: EMPTY, HOLD_A, HOLD_B. Reset state is EMPTY.
- Reset values:
  - a_valid=0, b_valid=0, busy=0
  - a_data=0, b_data=0
  - held data register = 0
  - in_ready=1, a combinational result of EMPTY
- Input acceptance: accept = in_valid && in_ready.
- in_ready = EMPTY || (HOLD_A && a_ready) || (HOLD_B && b_ready). It depends combinationally on a_ready/b_ready; there is no path from in_valid to in_ready.
- Output drain: drain = (HOLD_A && a_ready) || (HOLD_B && b_ready).
- Transitions:
  - EMPTY: on accept go to HOLD_A if in_sel=0, else HOLD_B; the data register loads in_data. Otherwise stay.
  - HOLD_x with drain and accept: go to the state selected by the new in_sel and load the new data. Back-to-back throughput is 1 word/cycle, including A->B and B->A switches.
  - HOLD_x with drain and no accept: go to EMPTY; the data register keeps its old value, but outputs show 0.
  - HOLD_x without drain: stay. Data, valid and state are frozen regardless of in_valid/in_sel changes.
- Outputs (all from registered state, no combinational input-to-output data path):
  - a_valid = (state==HOLD_A)
  - b_valid = (state==HOLD_B)
  - a_data = held data when HOLD_A, else 0
  - b_data = held data when HOLD_B, else 0
- Latency: a word accepted at edge N is visible on its output after edge N. It completes on the first edge with the matching ready high.
- Never asserts a_valid and b_valid together.
- Stalls:
  - Backpressure on the non-selected port has no effect.
  - A stalled port blocks all input, including words destined for the idle port, so ordering is strict.
- Simultaneous events:
  - Drain and accept on the same edge: drain wins the old word and the new word loads; no bubble, no loss.
  - a_ready/b_ready high while no valid is pending are ignored.
- Reset mid-operation: asserting rst_n low drops any held word immediately, asynchronously. Outputs go to reset values without waiting for a clock.
- X handling: in_data/in_sel are don't-care when in_valid=0 and must not alter state.

Optional Feature:
- Macro: MY_DMUX_STREAM_COUNT_EN
- Defined adds:
  - Output ports a_count and b_count, 16 bits each.
  - Each increments by 1 on every completed transfer on its port (valid && ready at the clock edge).
  - Each wraps from 0xFFFF to 0x0000.
  - Async reset to 0.
  - Counters have no effect on the handshake.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then release -> a_valid=b_valid=0, a_data=b_data=0, busy=0, in_ready=1. Assert rst_n=0 while in HOLD_B -> b_valid falls before the next clk edge.
- Single routes, WIDTH=8:
  - Push 0xA5 with sel=0, a_ready=1 -> one cycle later a_valid=1, a_data=0xA5, b_data=0, b_valid=0; returns to EMPTY next edge.
  - Repeat with sel=1 -> 0xA5 appears only on B.
- Streaming: a_ready=b_ready=1, push 0x01(sel0), 0x02(sel1), 0x03(sel0), 0x04(sel1) on consecutive cycles -> in_ready stays 1; outputs alternate A/B on four consecutive cycles with the matching data; no bubbles.
- Backpressure: push 0x11(sel0) with a_ready=0 for 5 cycles while in_valid=1 offers 0x22(sel1) -> in_ready=0, a_data stays 0x11, b_valid stays 0. Raise a_ready -> 0x11 completes, and 0x22 is accepted on the same edge and then shown on B.
- Idle-port ready ignored: b_ready toggling while EMPTY or HOLD_A -> no state change; b_valid stays 0.
- Counter, with MY_DMUX_STREAM_COUNT_EN defined: 3 A transfers and 2 B transfers -> a_count=3, b_count=2. Preload via 65536 A transfers -> a_count wraps to 0.
